// File: rtl/pipe_ctrl_chain_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_chain_if
//   Handshake/payload bundle for the pipe_ctrl_chain control pipeline.
//   Signals:
//     in_valid  - upstream has a real instruction's control bundle on in_data
//     in_data   - payload entering stage 0
//     in_ready  - stage 0 accepts in_data this cycle
//     out_valid - valid bit of the last stage
//     out_data  - payload of the last stage
//   Modports:
//     master - the side that feeds and observes the pipeline
//     slave  - the pipeline itself
// ----------------------------------------------------------------------------
interface pipe_ctrl_chain_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_chain
//   DEPTH-stage register chain carrying a WIDTH-bit control bundle plus a
//   valid bit per stage. Each stage can be stalled (held) or flushed
//   (turned into a bubble) independently; a stall also freezes every stage
//   upstream of it, and the stage just downstream of a stalled stage receives
//   a bubble. Bubbles always carry RESET_VALUE.
//   Ports:
//     clk         - clock, all state updates on the rising edge
//     n_rst       - asynchronous active-low reset
//     bus         - in_valid/in_data/in_ready/out_valid/out_data bundle
//     stall       - bit k: stage k holds its contents
//     flush       - bit k: stage k is cleared to a bubble (wins over stall)
//     stage_valid - valid bit of every stage
//     occupancy   - number of valid stages
//     bubble_cnt  - saturating count of cycles with out_valid = 0
// ----------------------------------------------------------------------------
module pipe_ctrl_chain #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16,
    localparam int              OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               n_rst,
    pipe_ctrl_chain_if.slave   bus,
    input  logic [DEPTH-1:0]   stall,
    input  logic [DEPTH-1:0]   flush,
    output logic [DEPTH-1:0]   stage_valid,
    output logic [OCC_W-1:0]   occupancy,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic [DEPTH-1:0] stallEff;   // stall[k] OR any downstream stall
    logic [DEPTH-1:0] stallPrev;  // bit k = stall[k-1], bit 0 = 0
    logic [DEPTH-1:0] srcValid;   // valid bit offered to stage k
    logic [DEPTH-1:0] validQ;
    logic [DEPTH-1:0] validD;
    logic [WIDTH-1:0] srcData [DEPTH];
    logic [WIDTH-1:0] dataQ   [DEPTH];
    logic [WIDTH-1:0] dataD   [DEPTH];

    // A stall at stage k must freeze everything upstream, so accumulate
    // from the output end back towards stage 0.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        stallEff = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc         = acc | stall[k];
            stallEff[k] = acc;
        end
    end

    // Shifting in a zero/in_valid and truncating keeps these expressions
    // legal for DEPTH = 1, where stage 0 has no upstream neighbour.
    assign stallPrev = DEPTH'({stall, 1'b0});
    assign srcValid  = DEPTH'({validQ, bus.in_valid});

    always_comb begin
        srcData[0] = bus.in_valid ? bus.in_data : RESET_VALUE;
        for (int k = 1; k < DEPTH; k++) begin
            srcData[k] = dataQ[k-1];
        end
    end

    // First matching rule wins: flush, hold, bubble behind a stall, load.
    // NOTE: every output of this block gets its hold value first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            validD[k] = validQ[k];
            dataD[k]  = dataQ[k];
            if (flush[k]) begin
                validD[k] = 1'b0;
                dataD[k]  = RESET_VALUE;
            end else if (stallEff[k]) begin
                validD[k] = validQ[k];
                dataD[k]  = dataQ[k];
            end else if (stallPrev[k]) begin
                validD[k] = 1'b0;
                dataD[k]  = RESET_VALUE;
            end else begin
                validD[k] = srcValid[k];
                dataD[k]  = srcData[k];
            end
        end
    end

    // NOTE: the payload registers are reset too, not just the valid bits,
    // because downstream logic relies on bubbles carrying RESET_VALUE.
    // NOTE: state registers use non-blocking assignments so every stage
    // samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            validQ     <= '0;
            dataQ      <= '{default: RESET_VALUE};
            bubble_cnt <= '0;
        end else begin
            validQ <= validD;
            dataQ  <= dataD;
            if (!validQ[DEPTH-1] && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(validQ[k]);
        end
    end

    assign bus.in_ready  = ~stallEff[0];
    assign bus.out_valid = validQ[DEPTH-1];
    assign bus.out_data  = dataQ[DEPTH-1];
    assign stage_valid   = validQ;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl_chain
//   Self-checking bench for pipe_ctrl_chain with WIDTH = 8, DEPTH = 3,
//   RESET_VALUE = 0 and CNT_W = 2. Directed scenarios check fixed expected
//   values; a randomized phase compares against a per-stage reference model.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl_chain;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 3;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [DEPTH-1:0] stall;
    logic [DEPTH-1:0] flush;
    logic [DEPTH-1:0] stage_valid;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    pipe_ctrl_chain_if #(.WIDTH(WIDTH)) bus ();

    pipe_ctrl_chain #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_VALUE(8'h00),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bus        (bus),
        .stall      (stall),
        .flush      (flush),
        .stage_valid(stage_valid),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one entry per stage, updated once per rising edge.
    bit         mValid [DEPTH];
    logic [7:0] mData  [DEPTH];
    int         mCnt;

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            mValid[k] = 1'b0;
            mData[k]  = 8'h00;
        end
        mCnt = 0;
    endtask

    task automatic model_step(input bit iv, input logic [7:0] id,
                              input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl);
        bit         nv [DEPTH];
        logic [7:0] nd [DEPTH];
        bit         blocked;
        blocked = 1'b0;
        if (!mValid[DEPTH-1] && mCnt < CNT_MAX) mCnt++;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            blocked = blocked | st[k];
            if (fl[k]) begin
                nv[k] = 1'b0; nd[k] = 8'h00;
            end else if (blocked) begin
                nv[k] = mValid[k]; nd[k] = mData[k];
            end else if (k > 0 && st[k-1]) begin
                nv[k] = 1'b0; nd[k] = 8'h00;
            end else if (k == 0) begin
                nv[k] = iv; nd[k] = iv ? id : 8'h00;
            end else begin
                nv[k] = mValid[k-1]; nd[k] = mData[k-1];
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            mValid[k] = nv[k];
            mData[k]  = nd[k];
        end
    endtask

    function automatic logic [DEPTH-1:0] exp_stage_valid();
        logic [DEPTH-1:0] v;
        for (int k = 0; k < DEPTH; k++) v[k] = mValid[k];
        return v;
    endfunction

    function automatic int exp_occupancy();
        int n;
        n = 0;
        for (int k = 0; k < DEPTH; k++) n += int'(mValid[k]);
        return n;
    endfunction

    task automatic set_inputs(input bit iv, input logic [7:0] id,
                              input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl);
        bus.in_valid = iv;
        bus.in_data  = id;
        stall        = st;
        flush        = fl;
    endtask

    // One rising edge; the model advances with the inputs present at the edge.
    task automatic tick();
        bit               iv;
        logic [7:0]       id;
        logic [DEPTH-1:0] st;
        logic [DEPTH-1:0] fl;
        iv = bus.in_valid; id = bus.in_data; st = stall; fl = flush;
        @(posedge clk);
        model_step(iv, id, st, fl);
        #1;
    endtask

    task automatic drive(input bit iv, input logic [7:0] id,
                         input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl);
        set_inputs(iv, id, st, fl);
        tick();
    endtask

    // Pulse reset low between clock edges, checking the immediate effect.
    task automatic pulse_reset(input string tag);
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (stage_valid !== 3'b000) begin
            errors++; $display("FAIL %s_stage_valid: got %b want 000", tag, stage_valid);
        end
        checks++;
        if (bubble_cnt !== 2'd0) begin
            errors++; $display("FAIL %s_bubble_cnt: got %0d want 0", tag, bubble_cnt);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++; $display("FAIL %s_out: got v=%b d=%h want v=0 d=00", tag, bus.out_valid, bus.out_data);
        end
        model_reset();
        #1 n_rst = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 8'h00) begin
            errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data);
        end
        checks++;
        if (stage_valid !== 3'b000) begin
            errors++; $display("FAIL reset_stage_valid: got %b want 000", stage_valid);
        end
        checks++;
        if (occupancy !== 2'd0) begin
            errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy);
        end
        checks++;
        if (bubble_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_stream();
        logic [7:0] expOut [3];
        expOut = '{8'h11, 8'h22, 8'h33};
        drive(1'b1, 8'h11, 3'b000, 3'b000);
        drive(1'b1, 8'h22, 3'b000, 3'b000);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_latency: out_valid got %b want 0 before cycle 3", bus.out_valid);
        end
        drive(1'b1, 8'h33, 3'b000, 3'b000);
        checks++;
        if (occupancy !== 2'd3 || stage_valid !== 3'b111) begin
            errors++; $display("FAIL stream_full: got occ=%0d sv=%b want occ=3 sv=111", occupancy, stage_valid);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== expOut[i]) begin
                errors++; $display("FAIL stream_out%0d: got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, expOut[i]);
            end
            drive(1'b0, 8'h00, 3'b000, 3'b000);
        end
    endtask

    task automatic test_stall_bubble();
        drive(1'b1, 8'h11, 3'b000, 3'b000);
        drive(1'b1, 8'h22, 3'b000, 3'b000);
        drive(1'b1, 8'h33, 3'b000, 3'b000);
        set_inputs(1'b1, 8'h44, 3'b010, 3'b000);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (stage_valid !== 3'b011 || occupancy !== 2'd2) begin
            errors++; $display("FAIL stall_hold: got sv=%b occ=%0d want sv=011 occ=2", stage_valid, occupancy);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++; $display("FAIL stall_bubble: got v=%b d=%h want v=0 d=00", bus.out_valid, bus.out_data);
        end
        // The held 0x22 in stage 1 moves on; 0x44 enters now that stall is gone.
        drive(1'b1, 8'h44, 3'b000, 3'b000);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22 || stage_valid !== 3'b111) begin
            errors++; $display("FAIL stall_resume: got v=%b d=%h sv=%b want v=1 d=22 sv=111", bus.out_valid, bus.out_data, stage_valid);
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 8'h55, 3'b100, 3'b100);
        checks++;
        if (stage_valid !== 3'b011 || bus.out_data !== 8'h00) begin
            errors++; $display("FAIL stallflush_clear: got sv=%b d=%h want sv=011 d=00", stage_valid, bus.out_data);
        end
        drive(1'b1, 8'h55, 3'b000, 3'b000);
        checks++;
        if (bus.out_data !== 8'h33 || stage_valid !== 3'b111) begin
            errors++; $display("FAIL stallflush_resume: got d=%h sv=%b want d=33 sv=111", bus.out_data, stage_valid);
        end
    endtask

    task automatic test_flush();
        // Pipe is 0x55/0x44/0x33 in stages 0/1/2.
        drive(1'b1, 8'h66, 3'b000, 3'b011);
        checks++;
        if (stage_valid !== 3'b100 || occupancy !== 2'd1) begin
            errors++; $display("FAIL flush_valid: got sv=%b occ=%0d want sv=100 occ=1", stage_valid, occupancy);
        end
        checks++;
        if (bus.out_data !== 8'h44) begin
            errors++; $display("FAIL flush_advance: got d=%h want 44", bus.out_data);
        end
        drive(1'b0, 8'h00, 3'b000, 3'b000);
        drive(1'b0, 8'h00, 3'b000, 3'b000);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++; $display("FAIL flush_nop_data: got v=%b d=%h want v=0 d=00", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'hA1, 3'b000, 3'b000);
        drive(1'b1, 8'hA2, 3'b000, 3'b000);
        drive(1'b1, 8'hA3, 3'b000, 3'b000);
        checks++;
        if (occupancy !== 2'd3) begin
            errors++; $display("FAIL areset_fill: got occ=%0d want 3", occupancy);
        end
        set_inputs(1'b0, 8'h00, 3'b000, 3'b000);
        pulse_reset("areset");
        drive(1'b1, 8'h77, 3'b000, 3'b000);
        checks++;
        if (stage_valid !== 3'b001 || bubble_cnt !== 2'd1) begin
            errors++; $display("FAIL areset_first_edge: got sv=%b cnt=%0d want sv=001 cnt=1", stage_valid, bubble_cnt);
        end
    endtask

    task automatic test_bubble_sat();
        int expCnt [5];
        expCnt = '{1, 2, 3, 3, 3};
        set_inputs(1'b0, 8'h00, 3'b000, 3'b000);
        pulse_reset("sat_reset");
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (int'(bubble_cnt) != expCnt[i]) begin
                errors++; $display("FAIL bubble_sat%0d: got %0d want %0d", i, bubble_cnt, expCnt[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [DEPTH-1:0] st;
        logic [DEPTH-1:0] fl;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                st[k] = ($urandom_range(6) == 0);
                fl[k] = ($urandom_range(12) == 0);
            end
            set_inputs(1'($urandom_range(3) != 0), 8'($urandom), st, fl);
            #1;
            checks++;
            if (bus.in_ready !== !(|st)) begin
                errors++; $display("FAIL rand_in_ready@%0d: got %b want %b", i, bus.in_ready, !(|st));
            end
            tick();
            checks++;
            if (bus.out_valid !== mValid[DEPTH-1] || bus.out_data !== mData[DEPTH-1]) begin
                errors++; $display("FAIL rand_out@%0d: got v=%b d=%h want v=%b d=%h", i, bus.out_valid, bus.out_data, mValid[DEPTH-1], mData[DEPTH-1]);
            end
            checks++;
            if (stage_valid !== exp_stage_valid() || int'(occupancy) != exp_occupancy()) begin
                errors++; $display("FAIL rand_stages@%0d: got sv=%b occ=%0d want sv=%b occ=%0d", i, stage_valid, occupancy, exp_stage_valid(), exp_occupancy());
            end
            checks++;
            if (int'(bubble_cnt) != mCnt) begin
                errors++; $display("FAIL rand_bubble_cnt@%0d: got %0d want %0d", i, bubble_cnt, mCnt);
            end
            // Occasionally restart so the saturating counter is exercised again.
            if (i % 100 == 99) begin
                set_inputs(1'b0, 8'h00, 3'b000, 3'b000);
                pulse_reset("rand_reset");
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        set_inputs(1'b0, 8'h00, 3'b000, 3'b000);
        model_reset();
        #17 n_rst = 1'b1;
        test_reset();
        test_stream();
        test_stall_bubble();
        test_stall_flush();
        test_flush();
        test_async_reset();
        test_bubble_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_chain.md
PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning payload (control bundle) width per stage, legal range >= 1.
REQ-002 The block SHALL have parameter DEPTH, default 3, meaning number of register stages, legal range >= 1.
REQ-003 The block SHALL have parameter RESET_VALUE, default 0, meaning the payload value loaded at reset and carried by every bubble (NOP).
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning bubble-counter width.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port n_rst, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning in_data holds a real instruction's control bundle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits, meaning payload entering stage 0.
REQ-009 The block SHALL have port stall, input, DEPTH bits, meaning bit k requests that stage k hold its contents.
REQ-010 The block SHALL have port flush, input, DEPTH bits, meaning bit k requests that stage k be cleared to a bubble.
REQ-011 The block SHALL have port in_ready, output, 1 bit, meaning stage 0 accepts in_data this cycle.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning valid bit of stage DEPTH-1.
REQ-013 The block SHALL have port out_data, output, WIDTH bits, meaning payload of stage DEPTH-1.
REQ-014 The block SHALL have port stage_valid, output, DEPTH bits, meaning valid bit of every stage (bit k = stage k).
REQ-015 The block SHALL have port occupancy, output, clog2(DEPTH+1) bits, meaning number of stages whose valid bit is 1.
REQ-016 The block SHALL have port bubble_cnt, output, CNT_W bits, meaning count of cycles with out_valid = 0.

Function
REQ-017 The block SHALL compute an effective stall: stall_eff[k] = OR of stall[j] for j = k..DEPTH-1 (a stall propagates to all upstream stages).
REQ-018 The block SHALL drive in_ready = ~stall_eff[0], combinationally.
REQ-019 The block SHALL, per stage k and per cycle, apply the first matching rule: (a) flush[k] = 1 -> valid 0, data RESET_VALUE; (b) stall_eff[k] = 1 -> hold; (c) k > 0 and stall[k-1] = 1 -> bubble (valid 0, data RESET_VALUE); (d) otherwise load from the source.
REQ-020 The source for stage 0 SHALL be in_valid/in_data, with data forced to RESET_VALUE when in_valid = 0; for stage k > 0 it SHALL be stage k-1 valid and data.
REQ-021 Flush SHALL take priority over stall on the same stage; a flush on stage k SHALL NOT affect any other stage.
REQ-022 The block SHALL maintain the invariant that any stage with valid = 0 holds data = RESET_VALUE.
REQ-023 Latency from in_data acceptance to out_data SHALL be exactly DEPTH cycles when no stall or flush is applied.
REQ-024 An instruction entering while in_ready = 0 SHALL NOT be captured; upstream logic must hold it.
REQ-025 The block SHALL derive occupancy combinationally as the popcount of stage_valid.
REQ-026 bubble_cnt SHALL increment by 1 on each rising edge where out_valid = 0 and SHALL saturate at 2^CNT_W - 1 (no wrap-around).
REQ-027 With DEPTH = 1, stall_eff[0] = stall[0], rule (c) SHALL never apply, and behaviour SHALL otherwise be unchanged.

Reset
REQ-028 When n_rst = 0, the block SHALL, asynchronously, clear all stage valid bits to 0, set all stage data to RESET_VALUE, and set bubble_cnt to 0, irrespective of clk.
REQ-029 After reset, outputs SHALL read out_valid = 0, out_data = RESET_VALUE, stage_valid = 0, and occupancy = 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight stages.
REQ-031 The first rising edge after n_rst deasserts SHALL follow the normal rules.

Verification (WIDTH = 8, DEPTH = 3, RESET_VALUE = 0)
REQ-032 Scenario: reset, then inputs 0x11, 0x22, 0x33 on consecutive cycles, no stall -> out_data = 0x11, 0x22, 0x33 in cycles 3-5; occupancy = 3 in cycle 3.
REQ-033 Scenario: pipe full with 0x33/0x22/0x11 (stage 0/1/2); stall = 3'b010 for one cycle -> stages 0-1 hold, stage 2 becomes a bubble (out_valid = 0, out_data = 0), in_ready = 0.
REQ-034 Scenario: stall = 3'b100 plus flush = 3'b100 in the same cycle -> stage 2 is cleared, and stages 0-1 hold.
REQ-035 Scenario: flush = 3'b011 with pipe full -> stages 0-1 become invalid with data 0x00, stage 2 advances normally, and occupancy drops to 1.
REQ-036 Scenario: CNT_W = 2, idle for 5 cycles -> bubble_cnt = 1, 2, 3, 3, 3.
REQ-037 Scenario: n_rst pulsed low between clock edges while the pipe is full -> stage_valid = 0 immediately; bubble_cnt = 0.
